multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 37 +++
 rtl/multicycle_control_class.sv | 23 ++
 rtl/multicycle_control.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle LEGv8 control unit: FSM states,
// instruction classes, ALU operation codes and opcode patterns.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_PC     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_LDUR    = 3'd1,
    CLS_STUR    = 3'd2,
    CLS_CBZ     = 3'd3,
    CLS_B       = 3'd4,
    CLS_ILLEGAL = 3'd7
  } insn_class_t;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_PASS_B = 2'b01;
  localparam logic [1:0] ALU_RTYPE  = 2'b10;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ_HI = 8'b10110100;
  localparam logic [5:0]  OP_B_HI   = 6'b000101;

endpackage

// File: rtl/multicycle_control_class.sv
// Combinational opcode classifier: maps instruction bits [31:21] to a class.
module insn_class_decode
  import multicycle_control_pkg::*;
(
  input  logic [10:0] opcode,
  output logic [2:0]  insn_class
);

  always_comb begin
    insn_class = CLS_ILLEGAL;
    if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR)
      insn_class = CLS_R;
    else if (opcode == OP_LDUR)
      insn_class = CLS_LDUR;
    else if (opcode == OP_STUR)
      insn_class = CLS_STUR;
    else if (opcode[10:3] == OP_CBZ_HI)
      insn_class = CLS_CBZ;
    else if (opcode[10:5] == OP_B_HI)
      insn_class = CLS_B;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back/PC
// steps, bounds memory wait states and latches branch-taken for the PC step.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic [1:0]  alu_op,
  output logic        alu_src,
  output logic        reg2_loc,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic [2:0]  state,
  output logic        fault
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_LIMIT - 1);

  state_t      cur_state, next_state;
  logic [2:0]  cls_bits;
  insn_class_t cls;
  logic [3:0]  wait_cnt;
  logic        taken;
  logic        wait_hit;

  insn_class_decode u_class (
    .opcode     (opcode),
    .insn_class (cls_bits)
  );

  assign cls      = insn_class_t'(cls_bits);
  assign state    = cur_state;
  assign wait_hit = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= S_FETCH;
    else       cur_state <= next_state;
  end

  // Counter is zero outside FETCH/MEM, so entering either state always starts a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wait_cnt <= '0;
    else if ((cur_state == S_FETCH && !imem_ready) || (cur_state == S_MEM && !dmem_ready))
      wait_cnt <= wait_cnt + 4'd1;
    else
      wait_cnt <= '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      taken <= 1'b0;
    else if (cur_state == S_EXEC && cls == CLS_CBZ)
      taken <= zero;
    else if (cur_state == S_EXEC && cls == CLS_B)
      taken <= 1'b1;
    else if (cur_state == S_PC)
      taken <= 1'b0;
  end

  always_comb begin
    next_state = cur_state;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    alu_op     = ALU_ADD;
    alu_src    = 1'b0;
    reg2_loc   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    fault      = 1'b0;
    unique case (cur_state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write   = 1'b1;
          next_state = S_DECODE;
        end else if (wait_hit) begin
          next_state = S_HALT;
        end
      end
      S_DECODE: next_state = (cls == CLS_ILLEGAL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        unique case (cls)
          CLS_R: begin
            alu_op     = ALU_RTYPE;
            next_state = S_WB;
          end
          CLS_LDUR, CLS_STUR: begin
            alu_src    = 1'b1;
            reg2_loc   = 1'b1;
            next_state = S_MEM;
          end
          CLS_CBZ: begin
            alu_op     = ALU_PASS_B;
            reg2_loc   = 1'b1;
            next_state = S_PC;
          end
          CLS_B:   next_state = S_PC;
          default: next_state = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_read  = (cls == CLS_LDUR);
        mem_write = (cls == CLS_STUR);
        if (cls != CLS_LDUR && cls != CLS_STUR)
          next_state = S_HALT;
        else if (dmem_ready)
          next_state = (cls == CLS_LDUR) ? S_WB : S_PC;
        else if (wait_hit)
          next_state = S_HALT;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls == CLS_LDUR);
        next_state = S_PC;
      end
      S_PC: begin
        pc_write   = 1'b1;
        pc_src     = taken;
        next_state = S_FETCH;
      end
      S_HALT:  fault = 1'b1;
      default: next_state = S_HALT;
    endcase
  end

endmodule
